// File: rtl/fpu_mul_iter_pkg.sv
// rtl/fpu_mul_iter_pkg.sv - shared float types, format constants and product alignment
package fpu_mul_iter_pkg;

  typedef enum logic [1:0] {
    HALF   = 2'd0,
    SINGLE = 2'd1,
    DOUBLE = 2'd2
  } floatType_t;

  // Value = (-1)^sign * 0.number * 2^exponent; exponent is two's complement.
  typedef struct packed {
    logic        sign;
    logic [15:0] exponent;
    logic [63:0] number;
  } denormalized_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  localparam int          HALF_EW     = 5;
  localparam int          SINGLE_EW   = 8;
  localparam int          DOUBLE_EW   = 11;
  localparam logic [5:0]  HALF_W      = 6'd11;
  localparam logic [5:0]  SINGLE_W    = 6'd24;
  localparam logic [5:0]  DOUBLE_W    = 6'd53;
  localparam logic [15:0] HALF_BIAS   = 16'd15;
  localparam logic [15:0] SINGLE_BIAS = 16'd127;
  localparam logic [15:0] DOUBLE_BIAS = 16'd1023;
  localparam logic [10:0] HALF_EMAX   = 11'((1 << HALF_EW) - 1);
  localparam logic [10:0] SINGLE_EMAX = 11'((1 << SINGLE_EW) - 1);
  localparam logic [10:0] DOUBLE_EMAX = 11'((1 << DOUBLE_EW) - 1);

  function automatic logic [5:0] mant_width(input floatType_t t);
    case (t)
      HALF:    return HALF_W;
      SINGLE:  return SINGLE_W;
      default: return DOUBLE_W;
    endcase
  endfunction

  // After W shift-add steps the product sits at acc[52+W : 53-W]; take its top 64 bits.
  function automatic logic [63:0] align_product(input logic [105:0] acc, input floatType_t t);
    case (t)
      HALF:    return acc[63:0];
      SINGLE:  return acc[76:13];
      default: return {acc[105:43], acc[42] | (|acc[41:0])};
    endcase
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// rtl/fpu_unpack.sv - combinational operand unpack: sign, unbiased exponent, mantissa, class
module fpu_unpack
  import fpu_mul_iter_pkg::*;
(
  input  logic [63:0] op,
  input  floatType_t  fmt,
  output logic        sign,
  output logic [15:0] exponent,
  output logic [52:0] mant,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  logic [10:0] w_e_field;
  logic [10:0] w_e_max;
  logic [52:0] w_frac;
  logic [52:0] w_hidden;
  logic [15:0] w_bias;

  always_comb begin
    sign      = op[63];
    w_e_field = op[62:52];
    w_frac    = {1'b0, op[51:0]};
    w_e_max   = DOUBLE_EMAX;
    w_hidden  = 53'd1 << 52;
    w_bias    = DOUBLE_BIAS;
    case (fmt)
      HALF: begin
        sign      = op[15];
        w_e_field = {6'd0, op[14:10]};
        w_frac    = {43'd0, op[9:0]};
        w_e_max   = HALF_EMAX;
        w_hidden  = 53'd1 << 10;
        w_bias    = HALF_BIAS;
      end
      SINGLE: begin
        sign      = op[31];
        w_e_field = {3'd0, op[30:23]};
        w_frac    = {30'd0, op[22:0]};
        w_e_max   = SINGLE_EMAX;
        w_hidden  = 53'd1 << 23;
        w_bias    = SINGLE_BIAS;
      end
      default: ;
    endcase

    // Subnormals use the minimum exponent with no hidden bit.
    if (w_e_field == 11'd0) begin
      exponent = 16'd1 - w_bias;
      mant     = w_frac;
    end else begin
      exponent = {5'd0, w_e_field} - w_bias;
      mant     = w_frac | w_hidden;
    end

    is_nan  = (w_e_field == w_e_max) && (w_frac != 53'd0);
    is_inf  = (w_e_field == w_e_max) && (w_frac == 53'd0);
    is_zero = (w_e_field == 11'd0) && (w_frac == 53'd0);
  end

endmodule

// File: rtl/fpu_mul_iter.sv
// rtl/fpu_mul_iter.sv - iterative shift-add floating-point multiplier producing a denormalized result
module fpu_mul_iter
  import fpu_mul_iter_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   op_a,
  input  logic [63:0]   op_b,
  input  floatType_t    fltType,
  output logic          out_valid,
  input  logic          out_ready,
  output denormalized_t result,
  output logic          is_zero,
  output logic          is_inf,
  output logic          is_nan
);

  logic          w_sign_a, w_sign_b;
  logic [15:0]   w_exp_a, w_exp_b;
  logic [52:0]   w_mant_a, w_mant_b;
  logic          w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic          w_res_nan, w_res_inf, w_res_zero, w_special;
  logic [5:0]    w_last_cnt;
  logic [53:0]   w_partial;
  logic [105:0]  w_acc_next;

  mul_state_t    r_state, w_next_state;
  floatType_t    r_fmt;
  logic [52:0]   r_mcand;
  logic [52:0]   r_mplier;
  logic [105:0]  r_acc;
  logic [5:0]    r_cnt;
  logic          r_sign;
  logic [15:0]   r_exp;
  denormalized_t r_result;
  logic          r_is_zero, r_is_inf, r_is_nan;

  fpu_unpack u_unpack_a (
    .op       (op_a),
    .fmt      (fltType),
    .sign     (w_sign_a),
    .exponent (w_exp_a),
    .mant     (w_mant_a),
    .is_zero  (w_zero_a),
    .is_inf   (w_inf_a),
    .is_nan   (w_nan_a)
  );

  fpu_unpack u_unpack_b (
    .op       (op_b),
    .fmt      (fltType),
    .sign     (w_sign_b),
    .exponent (w_exp_b),
    .mant     (w_mant_b),
    .is_zero  (w_zero_b),
    .is_inf   (w_inf_b),
    .is_nan   (w_nan_b)
  );

  // Priority NaN > inf > zero keeps at most one flag set.
  always_comb begin
    w_res_nan  = w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
    w_res_inf  = ~w_res_nan & (w_inf_a | w_inf_b);
    w_res_zero = ~w_res_nan & ~w_res_inf & (w_zero_a | w_zero_b);
    w_special  = w_res_nan | w_res_inf | w_res_zero;
  end

  assign w_last_cnt = mant_width(r_fmt) - 6'd1;

  // Add the multiplicand into the top half, then shift the whole accumulator right by one.
  assign w_partial  = {1'b0, r_acc[105:53]} + {1'b0, (r_mplier[0] ? r_mcand : 53'd0)};
  assign w_acc_next = {w_partial, r_acc[52:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next_state = w_special ? ST_DONE : ST_MUL;
      end
      ST_MUL: begin
        if (r_cnt == w_last_cnt) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fmt     <= HALF;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_exp     <= '0;
      r_result  <= '0;
      r_is_zero <= 1'b0;
      r_is_inf  <= 1'b0;
      r_is_nan  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_fmt     <= fltType;
            r_mcand   <= w_mant_a;
            r_mplier  <= w_mant_b;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sign    <= w_sign_a ^ w_sign_b;
            r_exp     <= w_exp_a + w_exp_b + 16'd2;
            r_is_zero <= w_res_zero;
            r_is_inf  <= w_res_inf;
            r_is_nan  <= w_res_nan;
            if (w_special) begin
              r_result <= '{sign: w_sign_a ^ w_sign_b, exponent: 16'd0, number: 64'd0};
            end
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 6'd1;
          if (r_cnt == w_last_cnt) begin
            r_result <= '{sign: r_sign, exponent: r_exp, number: align_product(w_acc_next, r_fmt)};
          end
        end
        default: ;
      endcase
    end
  end

  assign result  = r_result;
  assign is_zero = r_is_zero;
  assign is_inf  = r_is_inf;
  assign is_nan  = r_is_nan;

endmodule

// File: tb/tb_fpu_mul_iter.sv
// tb/tb_fpu_mul_iter.sv - directed bench for fpu_mul_iter against an arithmetic reference model
module tb_fpu_mul_iter;
  import fpu_mul_iter_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   op_a = '0;
  logic [63:0]   op_b = '0;
  floatType_t    fltType = HALF;
  logic          out_valid;
  logic          out_ready = 1'b0;
  denormalized_t result;
  logic          is_zero, is_inf, is_nan;

  int checks = 0;
  int errors = 0;

  logic          exp_active = 1'b0;
  denormalized_t exp_res;
  logic [2:0]    exp_flags;
  int            exp_lat;
  denormalized_t got_res;
  logic [2:0]    got_flags;
  int            got_lat;

  always #5 clk = ~clk;

  fpu_mul_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .fltType   (fltType),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .is_zero   (is_zero),
    .is_inf    (is_inf),
    .is_nan    (is_nan)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic decode(input floatType_t t, input logic [63:0] x, output logic s,
                        output int e, output logic [52:0] m,
                        output logic z, output logic inf, output logic nan);
    int ew, fw, bias, ef, emax;
    logic [52:0] frac;
    case (t)
      HALF:    begin ew = 5;  fw = 10; bias = 15;   end
      SINGLE:  begin ew = 8;  fw = 23; bias = 127;  end
      default: begin ew = 11; fw = 52; bias = 1023; end
    endcase
    emax = (1 << ew) - 1;
    ef   = int'((x >> fw) & ((64'd1 << ew) - 64'd1));
    frac = 53'(x & ((64'd1 << fw) - 64'd1));
    s    = x[ew + fw];
    e    = (ef == 0) ? 1 - bias : ef - bias;
    m    = (ef == 0) ? frac : (frac | (53'd1 << fw));
    nan  = (ef == emax) && (frac != 0);
    inf  = (ef == emax) && (frac == 0);
    z    = (ef == 0) && (frac == 0);
  endtask

  task automatic model(input floatType_t t, input logic [63:0] a, input logic [63:0] b);
    logic sa, sb, za, zb, ia, ib, na, nb, n, i, z;
    int ea, eb, w;
    logic [52:0] ma, mb;
    logic [105:0] p;
    logic [63:0] num;
    decode(t, a, sa, ea, ma, za, ia, na);
    decode(t, b, sb, eb, mb, zb, ib, nb);
    w = (t == HALF) ? 11 : (t == SINGLE) ? 24 : 53;
    n = na | nb | (ia & zb) | (za & ib);
    i = !n && (ia | ib);
    z = !n && !i && (za | zb);
    exp_flags = {z, i, n};
    if (n | i | z) begin
      exp_res = '{sign: sa ^ sb, exponent: 16'd0, number: 64'd0};
      exp_lat = 1;
    end else begin
      p = 106'(ma) * 106'(mb);
      if (w == 53) num = p[105:42] | {63'd0, |p[41:0]};
      else         num = 64'(p << (64 - 2 * w));
      exp_res = '{sign: sa ^ sb, exponent: 16'(ea + eb + 2), number: num};
      exp_lat = w + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_active) chk("unexpected_out_valid", 128'(out_valid), 128'(0));
      else chk("result_flags", {result, is_zero, is_inf, is_nan}, {exp_res, exp_flags});
    end
  end

  task automatic run_op(input floatType_t t, input logic [63:0] a, input logic [63:0] b, input int hold);
    int g;
    model(t, a, b);
    g = 0;
    while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
    op_a = a; op_b = b; fltType = t; in_valid = 1'b1; exp_active = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    fltType = floatType_t'($urandom_range(0, 2));
    got_lat = 1;
    while (!out_valid && got_lat < 200) begin @(posedge clk); #1; got_lat++; end
    got_res = result; got_flags = {is_zero, is_inf, is_nan};
    chk("latency", 128'(got_lat), 128'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1; op_a = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("hold_handshake", {in_ready, out_valid}, 2'b01);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; exp_active = 1'b0;
    chk("release_idle", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {in_ready, out_valid, result, is_zero, is_inf, is_nan}, {2'b10, 81'd0, 3'd0});
    @(negedge clk); rst_n = 1'b1;

    run_op(SINGLE, 64'h3FC00000, 64'h40000000, 0);
    chk("single_lit", {got_res, got_flags}, {1'b0, 16'd3, 64'h6000_0000_0000_0000, 3'b000});
    chk("single_lat", 128'(got_lat), 128'(25));

    run_op(HALF, 64'h3C00, 64'h3C00, 0);
    chk("half_lit", {got_res, got_flags}, {1'b0, 16'd2, 64'h4000_0000_0000_0000, 3'b000});
    chk("half_lat", 128'(got_lat), 128'(12));

    run_op(DOUBLE, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 0);
    chk("double_lit", {got_res, got_flags}, {1'b0, 16'd2, 64'h4000_0000_0000_0000, 3'b000});
    chk("double_lat", 128'(got_lat), 128'(54));

    run_op(SINGLE, 64'h7F800000, 64'h00000000, 2);
    chk("inf_x_zero_lit", {got_res.number, got_flags}, {64'd0, 3'b001});
    chk("special_lat", 128'(got_lat), 128'(1));

    run_op(SINGLE, 64'hBF800000, 64'h7F800000, 10);
    chk("neg_inf_lit", {got_res.sign, got_flags}, {1'b1, 3'b010});

    run_op(DOUBLE, 64'h3FF0_0000_0000_0001, 64'h3FF0_0000_0000_0001, 0);
    chk("sticky_lit", {got_res.exponent, got_res.number}, {16'd2, 64'h4000_0000_0000_0801});

    // Abandon an operation partway through the multiply.
    op_a = 64'h3FC00000; op_b = 64'h40000000; fltType = SINGLE; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    chk("reset_mid_mul", {in_ready, out_valid, result, is_zero, is_inf, is_nan}, {2'b10, 81'd0, 3'd0});
    @(negedge clk); rst_n = 1'b1;
    run_op(SINGLE, 64'h3FC00000, 64'h40000000, 0);
    chk("after_reset_lit", {got_res, got_lat}, {1'b0, 16'd3, 64'h6000_0000_0000_0000, 32'd25});

    run_op(SINGLE, 64'hC0400000, 64'h00000001, 0);
    run_op(HALF, 64'h7E00, 64'h3C00, 0);
    run_op(HALF, 64'h0000, 64'hBC00, 1);
    run_op(HALF, 64'hDEAD_BEEF_0000_3C00, 64'h1234_5678_9ABC_4000, 0);
    run_op(SINGLE, 64'hFFC00000, 64'h3F800000, 0);
    run_op(SINGLE, 64'hFF800000, 64'h7F800000, 0);
    run_op(DOUBLE, 64'h4009_21FB_5444_2D18, 64'hC005_BF0A_8B14_5769, 3);
    run_op(DOUBLE, 64'h7FEF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF, 0);
    run_op(DOUBLE, 64'h0000_0000_0000_0003, 64'h3FF8_0000_0000_0000, 0);
    run_op(SINGLE, 64'h00400000, 64'h3F800000, 0);
    run_op(HALF, 64'h03FF, 64'h7BFF, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_mul_iter.md
FPU_MUL_ITER -- requirements
Module: fpu_mul_iter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: in_valid  in  1  operands offered; in_ready  out  1  block idle and able to accept.
REQ-003 SHALL have ports: op_a, op_b  in  64 each  packed operands (HALF in [15:0], SINGLE in [31:0], DOUBLE in [63:0]; unused upper bits ignored).
REQ-004 SHALL have port: fltType  in  floatType_t  HALF/SINGLE/DOUBLE, sampled with operands.
REQ-005 SHALL have ports: out_valid  out  1  result held; out_ready  in  1  consumer (normalize stage) accepts.
REQ-006 SHALL have port: result  out  denormalized_t  {sign, exponent signed 16-bit unbiased, number[63:0]}.
REQ-007 SHALL have ports: is_zero, is_inf, is_nan  out  1 each  special-result flags, valid with out_valid.

Function
REQ-008 Value encoding: result = (-1)^sign * 0.number * 2^exponent (binary point left of bit 63).
REQ-009 Unpack: mantissa width W = 11/24/53 for HALF/SINGLE/DOUBLE; hidden bit 1 if exponent field nonzero, else 0 with unbiased exponent 1-bias.
REQ-010 sign = sign_a XOR sign_b for all results including specials.
REQ-011 exponent = ea_unbiased + eb_unbiased + 2.
REQ-012 Product P = ma*mb (2W bits), left-aligned so P[2W-1] maps to number[63]; for DOUBLE, the 42 discarded LSBs are ORed (sticky) into number[0].
REQ-013 Multiply is iterative shift-add, one multiplier bit per cycle, exactly W cycles in state MUL.
REQ-014 FSM states IDLE, MUL, DONE; IDLE->MUL on in_valid&in_ready with non-special operands; IDLE->DONE directly for specials; MUL->DONE after W iterations; DONE->IDLE on out_ready.
REQ-015 in_ready = 1 only in IDLE; out_valid = 1 only in DONE; result and flags stable while out_valid&!out_ready.
REQ-016 Latency: out_valid rises W+1 clocks after the accepting edge for normal operands; 1 clock for specials.
REQ-017 Specials: NaN if either operand NaN or inf*zero; else inf if either inf; else zero if either mantissa (incl. hidden) is zero; at most one flag set.
REQ-018 For special results number = 0 and exponent = 0; is_nan results carry sign per REQ-010.
REQ-019 in_valid during MUL/DONE is ignored (not captured); new operands accepted only in IDLE.
REQ-020 fltType held in a register at acceptance; input changes mid-operation have no effect.

Reset
REQ-021 rst_n low asynchronously forces IDLE, in_ready=1, out_valid=0, flags=0, result=0.
REQ-022 Reset mid-MUL or mid-DONE abandons the operation; no partial result is ever presented.
REQ-023 First acceptance allowed on the first rising edge after rst_n deasserts.

Structure
REQ-024 denormalized_t, floatType_t, per-format W/bias/exponent-width constants SHALL live in the shared floats package.
REQ-025 One sub-module fpu_unpack (combinational: sign, unbiased exponent, mantissa, is_zero/is_inf/is_nan per operand) SHALL be instantiated twice.
REQ-026 Iteration counter 6 bits; accumulator 106 bits; no multiplier macro inferred.

Verification
REQ-027 SINGLE 0x3FC00000 * 0x40000000 -> number 0x6000_0000_0000_0000, exponent 3, sign 0, out_valid 25 clocks after accept.
REQ-028 HALF 0x3C00 * 0x3C00 -> number 0x4000_0000_0000_0000, exponent 2, out_valid after 12 clocks; DOUBLE 0x3FF0...0 squared -> same number/exponent, sticky 0, 54 clocks.
REQ-029 SINGLE 0x7F800000 * 0x00000000 -> is_nan=1, number 0, out_valid 1 clock after accept, in_ready 0 until out_ready.
REQ-030 SINGLE 0xBF800000 * 0x7F800000 -> is_inf=1, sign 1; hold out_ready=0 10 cycles -> result/flags unchanged, in_valid ignored.
REQ-031 rst_n pulsed low at MUL iteration 10 -> next cycle in_ready=1, out_valid=0; following operation produces correct result.
REQ-032 DOUBLE 0x3FF0000000000001 * 0x3FF0000000000001 -> number[0] sticky = 1, exponent 2.
